chan_scan_mux: RTL and testbench

Parametrised N-channel, W-bit registered selector with complementary outputs and an automatic channel-scan mode. It picks one of N input words, registers the chosen word and its bitwise inverse, and tags the output with the channel it came from. It sits between a bank of sampled data sources and a single downstream consumer, such as a display or serial path. Channels are chosen either by a loaded select value or by a dwell-timed round-robin scan.

---
 rtl/chan_scan_mux.sv | 102 ++++++++++
 tb/tb_chan_scan_mux.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/chan_scan_mux.sv
// N-channel registered selector with complementary outputs, channel tag and
// dwell-timed round-robin scan. Manual loads take priority over the scan step.
module chan_scan_mux #(
    parameter int unsigned W     = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = $clog2(N),
    parameter int unsigned DWELL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*W-1:0]    in_bus,
    input  logic [SELW-1:0]   sel,
    input  logic              sel_load,
    input  logic              scan_en,
    input  logic              hold,
    output logic [W-1:0]      out,
    output logic [W-1:0]      outbar,
    output logic [SELW-1:0]   out_ch,
    output logic              out_valid,
    output logic [SELW-1:0]   cur_sel,
    output logic              sel_err
);

    localparam int unsigned       CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNTW-1:0]   CNT_LAST = CNTW'(DWELL - 1);
    localparam logic [SELW-1:0]   SEL_LAST = SELW'(N - 1);

    logic [W-1:0]    chan [N];
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_nxt;
    logic [SELW-1:0] sel_nxt;
    logic            err_nxt;
    logic            sel_ok;
    logic [W-1:0]    out_nxt;
    logic [SELW-1:0] ch_nxt;
    logic            valid_nxt;

    // Unpack the flat input bus into per-channel words
    for (genvar c = 0; c < N; c++) begin : g_chan
        assign chan[c] = in_bus[c*W +: W];
    end

    // State register: select, dwell counter, error pulse and output stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_sel   <= '0;
            cnt       <= '0;
            sel_err   <= 1'b0;
            out       <= '0;
            outbar    <= '1;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else begin
            cur_sel   <= sel_nxt;
            cnt       <= cnt_nxt;
            sel_err   <= err_nxt;
            out       <= out_nxt;
            outbar    <= ~out_nxt;
            out_ch    <= ch_nxt;
            out_valid <= valid_nxt;
        end
    end

    // Select update: legal load, else reject-and-maybe-scan, else scan/idle
    always_comb begin
        sel_nxt = cur_sel;
        cnt_nxt = cnt;
        err_nxt = 1'b0;
        sel_ok  = (32'(sel) < N);
        if (sel_load && sel_ok) begin
            sel_nxt = sel;
            cnt_nxt = '0;
        end else if (scan_en) begin
            err_nxt = sel_load;
            if (cnt == CNT_LAST) begin
                cnt_nxt = '0;
                sel_nxt = (cur_sel == SEL_LAST) ? '0 : cur_sel + SELW'(1);
            end else begin
                cnt_nxt = cnt + CNTW'(1);
            end
        end else begin
            err_nxt = sel_load;
            // A rejected load leaves the counter untouched
            if (!sel_load) begin
                cnt_nxt = '0;
            end
        end
    end

    // Output stage: sample the pre-edge channel unless frozen
    always_comb begin
        out_nxt   = out;
        ch_nxt    = out_ch;
        valid_nxt = out_valid;
        if (!hold) begin
            out_nxt   = chan[cur_sel];
            ch_nxt    = cur_sel;
            valid_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_chan_scan_mux.sv
// Randomized and directed check of chan_scan_mux against a rule-level model;
// instance a is N=4/DWELL=3, instance b is N=3/DWELL=1.
module tb_chan_scan_mux;

    localparam int W  = 8;
    localparam int NA = 4;
    localparam int DA = 3;
    localparam int NB = 3;
    localparam int DB = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] bus_a = '0;
    logic [23:0] bus_b = '0;
    logic [1:0]  sel = '0;
    logic        sel_load = 1'b0;
    logic        scan_en = 1'b0;
    logic        hold = 1'b0;

    logic [7:0]  out_a, outbar_a, out_b, outbar_b;
    logic [1:0]  out_ch_a, cur_sel_a, out_ch_b, cur_sel_b;
    logic        valid_a, err_a, valid_b, err_b;

    int n_checks = 0;
    int n_errors = 0;

    // Model state per instance (0 = a, 1 = b)
    int m_sel [2];
    int m_cnt [2];
    int m_out [2];
    int m_ch  [2];
    int m_val [2];
    int m_err [2];

    always #5 clk = ~clk;

    chan_scan_mux #(.W(W), .N(NA), .DWELL(DA)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_bus(bus_a), .sel(sel),
        .sel_load(sel_load), .scan_en(scan_en), .hold(hold),
        .out(out_a), .outbar(outbar_a), .out_ch(out_ch_a),
        .out_valid(valid_a), .cur_sel(cur_sel_a), .sel_err(err_a)
    );

    chan_scan_mux #(.W(W), .N(NB), .DWELL(DB)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_bus(bus_b), .sel(sel),
        .sel_load(sel_load), .scan_en(scan_en), .hold(hold),
        .out(out_b), .outbar(outbar_b), .out_ch(out_ch_b),
        .out_valid(valid_b), .cur_sel(cur_sel_b), .sel_err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the behavioural rules for instance k
    task automatic model_edge(input int k, input logic [31:0] bus);
        int n = (k == 0) ? NA : NB;
        int d = (k == 0) ? DA : DB;
        int s = m_sel[k];
        int req = int'(sel);
        if (!rst_n) begin
            m_sel[k] = 0; m_cnt[k] = 0; m_out[k] = 0;
            m_ch[k]  = 0; m_val[k] = 0; m_err[k] = 0;
            return;
        end
        if (!hold) begin
            m_out[k] = int'((bus >> (s * W)) & 32'hFF);
            m_ch[k]  = s;
            m_val[k] = 1;
        end
        m_err[k] = 0;
        if (sel_load && req < n) begin
            m_sel[k] = req;
            m_cnt[k] = 0;
        end else begin
            if (sel_load) m_err[k] = 1;
            if (scan_en) begin
                if (m_cnt[k] == d - 1) begin
                    m_cnt[k] = 0;
                    m_sel[k] = (s + 1) % n;
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end else if (!sel_load) begin
                m_cnt[k] = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("a.out",       32'(out_a),     32'(m_out[0]));
        check("a.outbar",    32'(outbar_a),  32'(~m_out[0] & 32'hFF));
        check("a.out_ch",    32'(out_ch_a),  32'(m_ch[0]));
        check("a.out_valid", 32'(valid_a),   32'(m_val[0]));
        check("a.cur_sel",   32'(cur_sel_a), 32'(m_sel[0]));
        check("a.sel_err",   32'(err_a),     32'(m_err[0]));
        check("b.out",       32'(out_b),     32'(m_out[1]));
        check("b.outbar",    32'(outbar_b),  32'(~m_out[1] & 32'hFF));
        check("b.out_ch",    32'(out_ch_b),  32'(m_ch[1]));
        check("b.out_valid", 32'(valid_b),   32'(m_val[1]));
        check("b.cur_sel",   32'(cur_sel_b), 32'(m_sel[1]));
        check("b.sel_err",   32'(err_b),     32'(m_err[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0, bus_a);
        model_edge(1, {8'h00, bus_b});
        #1;
        compare_all();
    endtask

    initial begin
        int seq [10];
        seq = '{2, 2, 2, 3, 3, 3, 0, 0, 0, 1};

        // Reset with random inputs for two edges
        rst_n = 1'b0;
        bus_a = $urandom; bus_b = 24'($urandom);
        sel = 2'($urandom); sel_load = 1'($urandom); scan_en = 1'($urandom); hold = 1'($urandom);
        step();
        step();
        check("rst.out",     32'(out_a),     32'h00);
        check("rst.outbar",  32'(outbar_a),  32'hFF);
        check("rst.out_ch",  32'(out_ch_a),  0);
        check("rst.valid",   32'(valid_a),   0);
        check("rst.cur_sel", 32'(cur_sel_a), 0);
        check("rst.sel_err", 32'(err_a),     0);

        // Manual load latency
        rst_n = 1'b1; hold = 1'b0; scan_en = 1'b0;
        bus_a = 32'h44332211; bus_b = 24'hCCBBAA;
        sel = 2'd2; sel_load = 1'b1;
        step();
        check("load.cur_sel", 32'(cur_sel_a), 2);
        sel_load = 1'b0;
        step();
        check("load.out",    32'(out_a),    32'h33);
        check("load.outbar", 32'(outbar_a), 32'hCC);
        check("load.out_ch", 32'(out_ch_a), 2);

        // Illegal select on the N=3 instance
        sel = 2'd1; sel_load = 1'b1;
        step();
        sel_load = 1'b0;
        step();
        sel = 2'd3; sel_load = 1'b1;
        step();
        check("ill.sel_err", 32'(err_b),     1);
        check("ill.cur_sel", 32'(cur_sel_b), 1);
        check("ill.out",     32'(out_b),     32'hBB);
        sel_load = 1'b0;
        step();
        check("ill.sel_err_drop", 32'(err_b),     0);
        check("ill.cur_sel_hold", 32'(cur_sel_b), 1);
        check("ill.out_hold",     32'(out_b),     32'hBB);

        // Scan wrap from channel 2 with DWELL=3
        sel = 2'd2; sel_load = 1'b1;
        step();
        check("scan.cur_sel0", 32'(cur_sel_a), 32'(seq[0]));
        sel_load = 1'b0; scan_en = 1'b1;
        for (int i = 1; i < 10; i++) begin
            step();
            check("scan.cur_sel", 32'(cur_sel_a), 32'(seq[i]));
            check("scan.out_ch",  32'(out_ch_a),  32'(seq[i-1]));
        end

        // Hold for five edges while scanning
        hold = 1'b1;
        for (int i = 0; i < 5; i++) step();
        hold = 1'b0;
        step();

        // Load at cnt==DWELL-1 wins over the scan advance
        sel = 2'd1; sel_load = 1'b1;
        step();
        sel_load = 1'b0;
        step();
        step();
        sel = 2'd0; sel_load = 1'b1;
        step();
        check("prio.cur_sel", 32'(cur_sel_a), 0);
        sel_load = 1'b0;
        step();
        step();
        check("prio.no_adv", 32'(cur_sel_a), 0);
        step();
        check("prio.adv", 32'(cur_sel_a), 1);

        // Reset mid-scan with hold asserted
        hold = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        check("mrst.cur_sel", 32'(cur_sel_a), 0);
        check("mrst.valid",   32'(valid_a),   0);
        check("mrst.outbar",  32'(outbar_a),  32'hFF);
        rst_n = 1'b1;
        step();
        check("mrst.dwell1", 32'(cur_sel_a), 0);
        step();
        check("mrst.dwell2", 32'(cur_sel_a), 0);
        step();
        check("mrst.adv", 32'(cur_sel_a), 1);
        check("mrst.held_valid", 32'(valid_a), 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst_n    = ($urandom_range(0, 49) != 0);
            bus_a    = $urandom;
            bus_b    = 24'($urandom);
            sel      = 2'($urandom);
            sel_load = ($urandom_range(0, 9) < 3);
            scan_en  = ($urandom_range(0, 9) < 7);
            hold     = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
